// File: rtl/seq_stim_scheduler.sv
// seq_stim_scheduler: drives a serial sequence detector with a latched pattern and counts its matches and toggles.
// Ports: clk, rst (async, active-high); start/pattern/len run request; det_x/det_rst detector drives;
// det_z detector output; busy/done handshake; match_cnt/toggle_cnt saturating activity counters.
// Build option: define SEQ_SCHED_TOGGLE_EN to implement toggle_cnt; otherwise it is tied to 0.
module seq_stim_scheduler #(
  parameter int PAT_W     = 16,
  parameter int LEN_W     = 5,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);
  typedef enum logic [2:0] {IDLE, PRIME, SHIFT, DRAIN, DONE} state_t;
  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, sh;
  logic [LEN_W-1:0] eff_q, eff_d, cnt_q, cnt_d, bidx;
  logic det_x_q, det_x_d, det_rst_q, det_rst_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic sample, clr;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return (s > MAX) ? MAX[CNT_W-1:0] : s[CNT_W-1:0];
  endfunction
  // bidx selects the next bit to present: eff-1 when leaving PRIME, cnt-1 while shifting
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    eff_d   = eff_q;
    cnt_d   = cnt_q;
    det_x_d = 1'b0;
    clr     = 1'b0;
    bidx    = (state_q == PRIME ? eff_q : cnt_q) - 1'b1;
    sh      = pat_q >> bidx;
    case (state_q)
      IDLE: if (start) begin
        state_d = PRIME;
        pat_d   = pattern;
        eff_d   = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
        clr     = 1'b1;
      end
      PRIME: if (eff_q == '0) state_d = DONE;
      else begin
        state_d = SHIFT;
        cnt_d   = bidx;
        det_x_d = sh[0];
      end
      SHIFT: if (cnt_q == '0) begin
        state_d = DRAIN;
        cnt_d   = LEN_W'(DRAIN_CYC - 1);
      end else begin
        cnt_d   = bidx;
        det_x_d = sh[0];
      end
      DRAIN: if (cnt_q == '0) state_d = DONE;
      else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    det_rst_d = (state_d == IDLE) || (state_d == PRIME) || (state_d == DONE);
    sample    = (state_q == SHIFT) || (state_q == DRAIN);
    match_d   = clr ? '0 : sample ? sat_add(match_q, {1'b0, det_z}) : match_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      eff_q     <= '0;
      cnt_q     <= '0;
      det_x_q   <= 1'b0;
      det_rst_q <= 1'b1;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      eff_q     <= eff_d;
      cnt_q     <= cnt_d;
      det_x_q   <= det_x_d;
      det_rst_q <= det_rst_d;
      match_q   <= match_d;
    end
  end
`ifdef SEQ_SCHED_TOGGLE_EN
  logic px_q, px_d, pz_q, pz_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  // only SHIFT compares det_x, so the forced zeros of DRAIN never register as toggles
  always_comb begin
    px_d  = clr ? 1'b0 : (state_q == SHIFT) ? det_x_q : px_q;
    pz_d  = clr ? 1'b0 : sample ? det_z : pz_q;
    tog_d = clr ? '0 : sample ? sat_add(tog_q, {1'b0, (state_q == SHIFT) && (det_x_q != px_q)} + {1'b0, det_z != pz_q}) : tog_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q  <= 1'b0;
      pz_q  <= 1'b0;
      tog_q <= '0;
    end else begin
      px_q  <= px_d;
      pz_q  <= pz_d;
      tog_q <= tog_d;
    end
  end
  assign toggle_cnt = tog_q;
`else
  assign toggle_cnt = '0;
`endif
  assign det_x     = det_x_q;
  assign det_rst   = det_rst_q;
  assign busy      = (state_q == PRIME) || (state_q == SHIFT) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign match_cnt = match_q;
endmodule

// File: doc/seq_stim_scheduler.md
# seq_stim_scheduler

Controller that sequences a serial sequence detector for activity/power characterisation. It accepts a pattern word with a start/busy/done handshake, holds the detector in reset, and releases it. It then shifts the pattern into the detector's `x` input one bit per clock, drains the detector, and counts detector matches and signal toggles as a switching-activity proxy. It sits between the estimation control logic and the `seq_detector` instance, replacing a hand-written stimulus bench.

## Interface
- `PAT_W`, 16: pattern register width, max bits per run.
- `LEN_W`, 5: width of `len`; must satisfy 2^LEN_W > PAT_W.
- `CNT_W`, 8: width of both counters.
- `DRAIN_CYC`, 2: cycles `det_z` keeps being sampled after the last bit.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `pattern`  in  PAT_W  bits to send; latched on accepted start; sent MSB-first from bit `len-1`.
- `len`  in  LEN_W  bits to send; latched on accepted start.
- `det_x`  out  1  registered drive to detector `x`.
- `det_rst`  out  1  registered drive to detector `rst`.
- `det_z`  in  1  detector output `z`.
- `busy`  out  1  high in PRIME, SHIFT and DRAIN.
- `done`  out  1  one-cycle pulse in DONE.
- `match_cnt`  out  CNT_W  number of sampled cycles with `det_z`=1; saturating.
- `toggle_cnt`  out  CNT_W  `det_x` plus `det_z` transitions; saturating.

## Operation
- States: IDLE, PRIME, SHIFT, DRAIN, DONE.
- **IDLE**
  - `start`=1 latches `pattern` and the effective length into `eff`.
  - `len` > `PAT_W` clamps to `PAT_W`.
  - Both counters clear, the previous-x and previous-z trackers clear to 0, and the state moves to PRIME.
- **PRIME**
  - One cycle with `det_rst`=1.
  - Moves to SHIFT if `eff` > 0, otherwise directly to DONE; counters stay 0.
- **SHIFT**
  - `det_rst`=0. `det_x` presents `pattern[eff-1]` down to `pattern[0]`, one bit per cycle, for `eff` cycles.
  - Then moves to DRAIN.
- **DRAIN**
  - `det_rst`=0 and `det_x`=0 for `DRAIN_CYC` cycles.
  - Then moves to DONE.
- **DONE**
  - `done`=1, `busy`=0, `det_rst`=1 for one cycle, then IDLE.
- `det_rst` is 1 in IDLE, PRIME and DONE.
- **Matches:** on every rising edge in SHIFT or DRAIN, `det_z`=1 increments `match_cnt`.
- **Toggles:**
  - In SHIFT, each cycle where `det_x` differs from the previous `det_x` adds 1.
  - In SHIFT or DRAIN, each sampled `det_z` that differs from the previous sample adds 1.
  - Both in the same cycle add 2.
  - DRAIN's forced `det_x`=0 is not counted.
- **Saturation:** both counters stick at 2^CNT_W−1, including when a +2 step would overflow.
- **Holding:** counters hold after DONE until the next accepted start.
- **Start while not idle:** `start` in any state other than IDLE is ignored, including the DONE cycle; it is accepted the following cycle if still high.
- **Reset:**
  - Asserting `rst`, at any time including mid-run, forces IDLE immediately with no `done` pulse.
  - Reset values: `det_x`=0, `det_rst`=1, `busy`=0, `done`=0, `match_cnt`=0, `toggle_cnt`=0; the pattern register and trackers are also 0.

## Timing
- Edge 0 is the rising edge that samples `start`=1 in IDLE; "after edge n" is the state held until edge n+1.
- After edge 1: PRIME, `busy`=1, `det_rst`=1.
- After edge 2: SHIFT, `det_rst`=0, `det_x`=`pattern[eff-1]`.
- After edge eff+1: `det_x`=`pattern[0]`.
- After edges eff+2 .. eff+1+DRAIN_CYC: DRAIN.
- After edge eff+2+DRAIN_CYC: DONE, `done`=1.
- After edge eff+3+DRAIN_CYC: IDLE; earliest next accept is at this edge.
- `eff`=0: DONE after edge 2, IDLE after edge 3.
- `det_z` is sampled at edges 3 .. eff+2+DRAIN_CYC, i.e. one edge after each SHIFT/DRAIN cycle begins.
- Counters update on those same edges; final values are valid while `done`=1.

## Configuration
- `SEQ_SCHED_TOGGLE_EN` defined: toggle trackers and `toggle_cnt` are implemented as specified.
- Not defined: no toggle logic is synthesised and `toggle_cnt` is constant 0.
- Port list and all other behaviour are identical in both builds.

## Test plan
- **Basic shift, no matches.** `pattern`=16'h000B, `len`=4, `det_z` tied 0.
  - `det_x`=1,0,1,1 after edges 2..5.
  - `done` after edge 8; `match_cnt`=0; `toggle_cnt`=3.
- **Constant match.** `pattern`=0, `len`=4, `det_z` tied 1.
  - `match_cnt`=6; `toggle_cnt`=1; `done` after edge 8.
- **Saturation.** `CNT_W`=4, `pattern`=16'hAAAA, `len`=16, `det_z` tied 1.
  - `match_cnt`=15; `toggle_cnt`=15.
- **Reset mid-run.** Assert `rst` during SHIFT after edge 4.
  - All outputs reach reset values immediately; no `done` pulse.
  - A new start after release runs normally.
- **Ignored start, zero length, clamp.**
  - `start` held high through a `len`=3 run: exactly one `done`, then a second run is accepted the cycle after DONE.
  - `len`=0: `done` after edge 2, counters 0.
  - `len`=20: behaves as 16.
- **Build without `SEQ_SCHED_TOGGLE_EN`.** Rerun the basic shift scenario: `toggle_cnt`=0, `match_cnt` and timing unchanged.
